// File: rtl/multicycle_maindec_pkg.sv
// Shared definitions for the multicycle MIPS main decoder: state codes,
// opcodes, ALU-op / operand-select / PC-select encodings and the packed
// control word produced by the output decoder. The ALU decoder imports
// the same package so the aluop encoding has a single definition.
package multicycle_maindec_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_maindec_if.sv
// Bundle between the datapath and the main decoder.
//   op, mem_ready       : datapath -> decoder (opcode, memory done)
//   control strobes/sels: decoder -> datapath
//   state               : debug view of the current state code
// master = datapath side, slave = decoder side.
interface multicycle_maindec_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output op, mem_ready,
    input  pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, aluop, illegal_op, state
  );

  modport slave (
    input  op, mem_ready,
    output pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, aluop, illegal_op, state
  );
endinterface

// File: rtl/multicycle_maindec_outdec.sv
// Combinational control-word decode for the multicycle main decoder.
//   state_i     : current state
//   op_i        : opcode (only used to flag unsupported opcodes in DECODE)
//   mem_ready_i : gates the fetch strobes
//   rst_i       : while high, decode as FETCH with every write strobe off
//   ctrl_o      : control word
module multicycle_outdec
  import multicycle_maindec_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  input  logic       rst_i,
  output ctrl_t      ctrl_o
);

  state_e st;

  always_comb begin
    ctrl_o = '0;
    st     = rst_i ? S_FETCH : state_i;
    case (st)
      S_FETCH: begin
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        // IR and PC load together on the cycle the read returns.
        ctrl_o.irwrite = mem_ready_i & ~rst_i;
        ctrl_o.pcwrite = mem_ready_i & ~rst_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb    = SRCB_IMMSH;
        ctrl_o.aluop      = ALUOP_ADD;
        ctrl_o.illegal_op = ~op_supported(op_i);
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        // Held for the whole wait so the memory sees a stable request.
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: ctrl_o.regwrite = 1'b1;
      S_JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle MIPS main decoder: state register and next-state logic; the
// control word comes from multicycle_outdec.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, returns to FETCH
//   bus : slave side of multicycle_maindec_if
//
// state  | meaning
// FETCH  | read instruction at PC, wait for mem_ready
// DECODE | read registers, branch target into ALUOut, dispatch on op
// MEMADR | compute load/store address
// MEMRD  | load read, wait for mem_ready
// MEMWB  | write load data to rt
// MEMWR  | store write, wait for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare for beq, conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | write addi result to rt
// JUMP   | load jump target into PC
module multicycle_maindec
  import multicycle_maindec_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  multicycle_maindec_if.slave  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR; anything not sw is treated as a load.
      S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  multicycle_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (bus.op),
    .mem_ready_i (bus.mem_ready),
    .rst_i       (rst),
    .ctrl_o      (ctrl)
  );

  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.branch     = ctrl.branch;
  assign bus.iord       = ctrl.iord;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.aluop      = ctrl.aluop;
  assign bus.illegal_op = ctrl.illegal_op;
  // Reset is synchronous, but the debug view reads FETCH while it is held.
  assign bus.state      = rst ? 4'd0 : state_q;

endmodule
